ebus_diag_arbiter: RTL and testbench

- Shares the EBUS diagnostic path (ds select, diagStrobe, 36-bit data drive/sample) between NREQ requesters, e.g. DTE front end (req 0) and console/scan engine (req 1).
- Grants round-robin, then sequences each transaction through setup/strobe/sample/hold phases and returns sampled EBUS data to the winner.
- Replaces ad-hoc single-cycle strobing with timed phases.

---
 rtl/ebus_diag_pkg.sv | 30 +++
 rtl/ebus_rr_arbiter.sv | 36 +++
 rtl/ebus_diag_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ebus_diag_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_diag_pkg.sv
// Shared types for the EBUS diagnostic arbiter: op codes, arbiter states, bus widths.
// EBUS_DIAG_LOCK_EN adds the LOCKED state to the state type.
package ebus_diag_pkg;

    localparam int DS_W   = 7;
    localparam int WORD_W = 36;

    typedef enum logic [1:0] {
        diagRead    = 2'd0,
        diagWrite   = 2'd1,
        diagFunc    = 2'd2,
        diagRelease = 2'd3
    } tDiagOp;

`ifdef EBUS_DIAG_LOCK_EN
    typedef enum logic [2:0] {
        ARB_IDLE, ARB_SETUP, ARB_STROBE, ARB_SAMPLE, ARB_HOLD, ARB_RESP, ARB_LOCKED
    } tArbState;
`else
    typedef enum logic [2:0] {
        ARB_IDLE, ARB_SETUP, ARB_STROBE, ARB_SAMPLE, ARB_HOLD, ARB_RESP
    } tArbState;
`endif

    // Only ops that act on the bus fire diagStrobe; read and release just sample.
    function automatic logic op_strobes(tDiagOp op);
        return (op == diagWrite) || (op == diagFunc);
    endfunction

endpackage

// File: rtl/ebus_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
// Zero latency; no state, the owner decides when a grant is taken.
module ebus_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            pos = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
            if (!any && valid[pos]) begin
                any        = 1'b1;
                idx        = pos;
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ebus_diag_arbiter.sv
// Round-robin share of the EBUS diag path with timed setup/strobe/sample/hold phases; EBUS_DIAG_LOCK_EN adds reqLock/LOCKED.
// Grant to rspValid is 1+SETUP+STROBE+1+HOLD cycles (no STROBE for read/release); no new grant until rspReady takes the response.
module ebus_diag_arbiter
    import ebus_diag_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [NREQ-1:0]        reqValid,
    output logic [NREQ-1:0]        reqReady,
    input  logic [NREQ*2-1:0]      reqOp,
    input  logic [NREQ*DS_W-1:0]   reqDs,
    input  logic [NREQ*WORD_W-1:0] reqData,
`ifdef EBUS_DIAG_LOCK_EN
    input  logic [NREQ-1:0]        reqLock,
`endif
    output logic [NREQ-1:0]        rspValid,
    input  logic [NREQ-1:0]        rspReady,
    output logic [WORD_W-1:0]      rspData,
    output logic [DS_W-1:0]        ebusDs,
    output logic                   ebusDiagStrobe,
    output logic                   ebusDriving,
    output logic [WORD_W-1:0]      ebusDriveData,
    input  logic [WORD_W-1:0]      ebusData,
    output logic                   busy
);

    localparam int            IW       = $clog2(NREQ);
    localparam logic [IW-1:0] LAST     = IW'(NREQ - 1);
    localparam logic [3:0]    SETUP_N  = 4'(SETUP_CYC);
    localparam logic [3:0]    STROBE_N = 4'(STROBE_CYC);
    localparam logic [3:0]    HOLD_N   = 4'(HOLD_CYC);

    tArbState          state;
    logic [3:0]        cnt;
    tDiagOp            op_q;
    logic [NREQ-1:0]   win_oh_q;
    logic [IW-1:0]     rr_ptr;

    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     grant_idx;
    logic              grant_any;
    logic              can_grant;
    logic              take;
    logic              go_resp;
    logic              rsp_ack;
    logic              keep_drive;
    tArbState          resp_exit;

    logic [1:0]        sel_op_bits;
    tDiagOp            sel_op;
    logic [DS_W-1:0]   sel_ds;
    logic [WORD_W-1:0] sel_data;

`ifdef EBUS_DIAG_LOCK_EN
    logic              lock_q;
    logic              sel_lock;

    // While locked only the lock owner may compete; its driver state survives RESP.
    assign elig       = (state == ARB_LOCKED) ? (reqValid & win_oh_q) : reqValid;
    assign can_grant  = (state == ARB_IDLE) || (state == ARB_LOCKED);
    assign keep_drive = lock_q && (op_q != diagRelease);
    assign resp_exit  = keep_drive ? ARB_LOCKED : ARB_IDLE;
`else
    assign elig       = reqValid;
    assign can_grant  = (state == ARB_IDLE);
    assign keep_drive = 1'b0;
    assign resp_exit  = ARB_IDLE;
`endif

    ebus_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .valid (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin
        sel_op_bits = '0;
        sel_ds      = '0;
        sel_data    = '0;
`ifdef EBUS_DIAG_LOCK_EN
        sel_lock    = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op_bits = reqOp[i*2 +: 2];
                sel_ds      = reqDs[i*DS_W +: DS_W];
                sel_data    = reqData[i*WORD_W +: WORD_W];
`ifdef EBUS_DIAG_LOCK_EN
                sel_lock    = reqLock[i];
`endif
            end
        end
    end

    assign sel_op   = tDiagOp'(sel_op_bits);
    assign take     = can_grant && grant_any && resetN;
    assign reqReady = take ? grant : '0;
    assign rsp_ack  = |(rspValid & rspReady);
    assign go_resp  = ((state == ARB_SAMPLE) && (HOLD_CYC == 0)) ||
                      ((state == ARB_HOLD) && (cnt == 4'd1));
    assign busy     = (state != ARB_IDLE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= ARB_IDLE;
            cnt            <= '0;
            op_q           <= diagRead;
            win_oh_q       <= '0;
            rr_ptr         <= '0;
            rspValid       <= '0;
            rspData        <= '0;
            ebusDs         <= '0;
            ebusDiagStrobe <= 1'b0;
            ebusDriving    <= 1'b0;
            ebusDriveData  <= '0;
`ifdef EBUS_DIAG_LOCK_EN
            lock_q         <= 1'b0;
`endif
        end else begin
            case (state)
`ifdef EBUS_DIAG_LOCK_EN
                ARB_IDLE, ARB_LOCKED: begin
`else
                ARB_IDLE: begin
`endif
                    if (take) begin
                        op_q     <= sel_op;
                        win_oh_q <= grant;
                        rr_ptr   <= (grant_idx == LAST) ? '0 : grant_idx + IW'(1);
                        state    <= ARB_SETUP;
                        cnt      <= SETUP_N;
                        ebusDs   <= sel_ds;
`ifdef EBUS_DIAG_LOCK_EN
                        lock_q   <= sel_lock;
`endif
                        if (sel_op == diagWrite) begin
                            ebusDriving   <= 1'b1;
                            ebusDriveData <= sel_data;
                        end
                    end
                end
                ARB_SETUP: begin
                    if (cnt == 4'd1) begin
                        if (op_strobes(op_q)) begin
                            state          <= ARB_STROBE;
                            cnt            <= STROBE_N;
                            ebusDiagStrobe <= 1'b1;
                        end else begin
                            state <= ARB_SAMPLE;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ARB_STROBE: begin
                    if (cnt == 4'd1) state <= ARB_SAMPLE;
                    else             cnt   <= cnt - 4'd1;
                end
                ARB_SAMPLE: begin
                    rspData        <= ebusData;
                    ebusDiagStrobe <= 1'b0;
                    if (HOLD_CYC != 0) begin
                        state <= ARB_HOLD;
                        cnt   <= HOLD_N;
                    end
                end
                ARB_HOLD: begin
                    if (cnt != 4'd1) cnt <= cnt - 4'd1;
                end
                ARB_RESP: begin
                    if (rsp_ack) begin
                        rspValid <= '0;
                        state    <= resp_exit;
                    end
                end
                default: state <= ARB_IDLE;
            endcase

            // Shared RESP entry from SAMPLE (no hold) or the last HOLD cycle.
            if (go_resp) begin
                state       <= ARB_RESP;
                rspValid    <= win_oh_q;
                ebusDs      <= '0;
                ebusDriving <= keep_drive ? ebusDriving : 1'b0;
                if (op_q == diagRelease) ebusDriveData <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ebus_diag_arbiter.sv
// Directed bench for ebus_diag_arbiter with a per-cycle timeline model of the bus phases.
module tb_ebus_diag_arbiter;

    localparam int NREQ = 2, SETUP_CYC = 2, STROBE_CYC = 3, HOLD_CYC = 1;

    logic                 clk = 1'b0;
    logic                 resetN;
    logic [NREQ-1:0]      reqValid, reqReady, rspValid, rspReady;
    logic [NREQ*2-1:0]    reqOp;
    logic [NREQ*7-1:0]    reqDs;
    logic [NREQ*36-1:0]   reqData;
    logic [35:0]          rspData, ebusDriveData, ebusData;
    logic [6:0]           ebusDs;
    logic                 ebusDiagStrobe, ebusDriving, busy;

    int checks = 0, errors = 0, cyc = 0;

    ebus_diag_arbiter #(.NREQ(NREQ), .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqDs(reqDs), .reqData(reqData), .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .ebusDs(ebusDs), .ebusDiagStrobe(ebusDiagStrobe), .ebusDriving(ebusDriving),
        .ebusDriveData(ebusDriveData), .ebusData(ebusData), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int strobe_len(input logic [1:0] op);
        return (op == 2'd1 || op == 2'd2) ? STROBE_CYC : 0;
    endfunction

    // Model: an idle cycle grants the first valid at/after ptr; an active transaction
    // is described purely by its offset t from the grant cycle.
    int          m_active = 0, m_t = 0, m_win = 0, m_ptr = 0, w, j, samp, rs;
    logic [1:0]  m_op;
    logic [6:0]  m_ds, e_ds;
    logic [35:0] m_data, m_rsp;
    logic [NREQ-1:0] e_rdy, e_rv;
    logic        e_stb, e_drv;

    initial begin
        m_op = '0; m_ds = '0; m_data = '0; m_rsp = '0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                chk("rst_reqReady", reqReady, 0);
                chk("rst_rspValid", rspValid, 0);
                chk("rst_rspData", rspData, 0);
                chk("rst_ds", ebusDs, 0);
                chk("rst_strobe", ebusDiagStrobe, 0);
                chk("rst_driving", ebusDriving, 0);
                chk("rst_busy", busy, 0);
                m_active = 0;
                m_ptr    = 0;
                m_rsp    = '0;
            end else begin
                e_rdy = '0; e_rv = '0; e_ds = '0; e_stb = 1'b0; e_drv = 1'b0; w = 0;
                samp = SETUP_CYC + strobe_len(m_op) + 1;
                rs   = samp + HOLD_CYC + 1;
                if (m_active == 0) begin
                    for (int i = NREQ - 1; i >= 0; i--) begin
                        j = (m_ptr + i) % NREQ;
                        if (reqValid[j]) w = j;
                    end
                    if (reqValid != 0) e_rdy[w] = 1'b1;
                end else if (m_t < rs) begin
                    e_ds  = m_ds;
                    e_drv = (m_op == 2'd1);
                    e_stb = (strobe_len(m_op) > 0) && (m_t > SETUP_CYC) && (m_t <= samp);
                end else begin
                    e_rv[m_win] = 1'b1;
                end
                chk("reqReady", reqReady, e_rdy);
                chk("rspValid", rspValid, e_rv);
                chk("busy", busy, m_active != 0);
                chk("ebusDs", ebusDs, e_ds);
                chk("strobe", ebusDiagStrobe, e_stb);
                chk("driving", ebusDriving, e_drv);
                if (e_drv) chk("driveData", ebusDriveData, m_data);
                if (e_rv != 0) chk("rspData", rspData, m_rsp);
                if (m_active == 0) begin
                    if (e_rdy != 0) begin
                        m_active = 1; m_t = 1; m_win = w;
                        m_op   = reqOp[w*2 +: 2];
                        m_ds   = reqDs[w*7 +: 7];
                        m_data = reqData[w*36 +: 36];
                        m_ptr  = (w + 1) % NREQ;
                    end
                end else begin
                    if (m_t == samp) m_rsp = ebusData;
                    if (m_t >= rs && rspReady[m_win]) m_active = 0;
                    else m_t++;
                end
            end
        end
    end

    task automatic do_txn(input int r, input logic [1:0] op, input logic [6:0] ds, input logic [35:0] d,
                          input int stall, output int lat, output logic [15:0] stb,
                          output logic [15:0] drv, output logic [35:0] rd);
        bit got;
        reqOp[r*2 +: 2]    = op;
        reqDs[r*7 +: 7]    = ds;
        reqData[r*36 +: 36] = d;
        reqValid[r]        = 1'b1;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = reqReady[r];
        end
        chk("grant_seen", got, 1);
        @(posedge clk); #1;
        reqValid[r] = 1'b0;
        lat = 0; stb = '0; drv = '0; rd = '0; got = 0;
        for (int k = 1; k < 16 && !got; k++) begin
            @(negedge clk);
            lat = k; stb[k] = ebusDiagStrobe; drv[k] = ebusDriving;
            got = rspValid[r]; rd = rspData;
        end
        chk("rsp_seen", got, 1);
        repeat (stall) @(posedge clk);
        @(posedge clk); #1;
        rspReady[r] = 1'b1;
        @(posedge clk); #1;
        rspReady[r] = 1'b0;
    endtask

    int          lat, ones;
    logic [15:0] stb, drv;
    logic [35:0] rd;
    bit          got;
    logic [3:0]  ord;

    initial begin
        resetN = 1'b0; reqValid = '0; rspReady = '0; reqOp = '0; reqDs = '0; reqData = '0;
        ebusData = 36'o777000_000777;
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;

        // Write from req0 with default timing.
        do_txn(0, 2'd1, 7'o34, 36'o123456_654321, 0, lat, stb, drv, rd);
        chk("wr_latency", lat, 8);
        chk("wr_strobe_map", stb, 16'b0000_0000_0111_1000);
        chk("wr_drive_map", drv, 16'b0000_0000_1111_1110);

        // Read from req1: no strobe, short latency.
        do_txn(1, 2'd0, 7'o12, 36'o0, 0, lat, stb, drv, rd);
        chk("rd_latency", lat, 5);
        chk("rd_strobe_map", stb, 0);
        chk("rd_drive_map", drv, 0);
        chk("rd_data", rd, 36'o777000_000777);

        // diagFunc with a long response stall while req1 waits.
        ebusData = 36'o012345_670123;
        reqOp[2 +: 2] = 2'd0; reqDs[7 +: 7] = 7'o21; reqValid[1] = 1'b1;
        do_txn(0, 2'd2, 7'o41, 36'o0, 20, lat, stb, drv, rd);
        chk("fn_latency", lat, 8);
        chk("fn_data", rd, 36'o012345_670123);
        do_txn(1, 2'd0, 7'o21, 36'o0, 0, lat, stb, drv, rd);
        chk("rd2_latency", lat, 5);

        // Write then release: release clears the drive data.
        do_txn(0, 2'd1, 7'o3, 36'o555555_222222, 0, lat, stb, drv, rd);
        do_txn(0, 2'd3, 7'o1, 36'o0, 0, lat, stb, drv, rd);
        chk("rel_latency", lat, 5);
        chk("rel_strobe_map", stb, 0);
        chk("rel_driveData", ebusDriveData, 0);

        // Reset in the middle of STROBE.
        reqOp[2 +: 2] = 2'd1; reqDs[7 +: 7] = 7'o55; reqData[36 +: 36] = 36'o707070_707070; reqValid[1] = 1'b1;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin @(negedge clk); got = reqReady[1]; end
        chk("rst_case_grant", got, 1);
        @(posedge clk); #1;
        reqValid[1] = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = ebusDiagStrobe; end
        chk("rst_case_strobe_seen", got, 1);
        #2 resetN = 1'b0;
        #1;
        chk("async_strobe", ebusDiagStrobe, 0);
        chk("async_driving", ebusDriving, 0);
        chk("async_ds", ebusDs, 0);
        chk("async_rspValid", rspValid, 0);
        chk("async_busy", busy, 0);
        @(posedge clk); @(posedge clk); #1;
        resetN = 1'b1;

        // Both requesters valid: round-robin from ptr 0.
        reqOp = {2'd2, 2'd1}; reqDs = {7'o66, 7'o11};
        reqData = {36'o111111_000000, 36'o000000_222222};
        reqValid = 2'b11;
        ord = '0;
        for (int n = 0; n < 4; n++) begin
            got = 0; ones = 0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (reqReady != 0) begin
                    got = 1; ord[n] = reqReady[1]; ones = $countones(reqReady);
                end
            end
            chk("rr_grant_seen", got, 1);
            chk("rr_onehot", ones, 1);
            if (n == 3) begin
                @(posedge clk); #1;
                reqValid = '0;
            end
            got = 0;
            for (int k = 0; k < 30 && !got; k++) begin @(negedge clk); got = (rspValid != 0); end
            chk("rr_rsp_seen", got, 1);
            @(posedge clk); #1;
            rspReady = rspValid;
            @(posedge clk); #1;
            rspReady = '0;
        end
        chk("rr_order", ord, 4'b1010);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
